// File: rtl/prefetch_arb_pkg.sv
// Shared definitions for the prefetch FIFO read arbiter: FSM encoding and
// a width helper that never returns zero.
package prefetch_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2
    } arb_state_e;

    // Index width for n items; at least 1 bit so single-value fields stay legal.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search starting one past the previous winner.
module rr_pick
    import prefetch_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    // cand[k] is the source visited k+1 steps after last_grant.
    logic [IDX_W-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(last_grant) + gi + 1) % N);
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest requester wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_fifo_rd_arb.sv
// Burst arbiter over N show-ahead prefetch FIFO read ports with round-robin
// grants, fixed-length bursts and an idle timeout that aborts a starved burst.
module prefetch_fifo_rd_arb
    import prefetch_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_SRC-1:0]           src_vld,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    output logic [N_SRC-1:0]           src_rd_en,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [clog2w(N_SRC)-1:0]   m_id,
    output logic                       m_last,
    output logic                       burst_abort,
    output logic                       busy
);

    localparam int ID_W   = clog2w(N_SRC);
    localparam int BEAT_W = clog2w(BURST_LEN);
    localparam int IDLE_W = clog2w(TIMEOUT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]   SRC_LAST  = ID_W'(N_SRC - 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic [DATA_W-1:0] src_word [N_SRC];
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              in_burst;
    logic              cur_vld;
    logic              xfer;
    logic              beat_is_last;
    logic              timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign src_word[gi]  = src_data[gi*DATA_W +: DATA_W];
            assign src_rd_en[gi] = xfer & (grant_q == ID_W'(gi));
        end
    endgenerate

    rr_pick #(
        .N     (N_SRC),
        .IDX_W (ID_W)
    ) u_pick (
        .req        (src_vld),
        .last_grant (last_grant_q),
        .winner     (pick_idx),
        .any        (pick_any)
    );

    // The datapath is a combinational window onto the granted FIFO head.
    assign in_burst     = (state_q == ST_BURST);
    assign cur_vld      = src_vld[grant_q];
    assign m_valid      = in_burst & cur_vld;
    assign m_data       = in_burst ? src_word[grant_q] : '0;
    assign m_id         = grant_q;
    assign beat_is_last = (beat_q == BEAT_LAST);
    assign m_last       = m_valid & beat_is_last;
    assign xfer         = m_valid & m_ready;
    assign timeout_hit  = in_burst & ~cur_vld & (idle_q == IDLE_LAST);
    assign burst_abort  = timeout_hit;
    assign busy         = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        idle_d       = idle_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && pick_any) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                beat_d  = '0;
                idle_d  = '0;
                state_d = ST_BURST;
            end
            ST_BURST: begin
                // A stalled beat still has its head word, so it resets the idle run.
                if (cur_vld) begin
                    idle_d = '0;
                end else if (idle_q != IDLE_LAST) begin
                    idle_d = idle_q + 1'b1;
                end
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_is_last) begin
                        state_d = ST_IDLE;
                    end
                end
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_LAST;
            beat_q       <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            idle_q       <= idle_d;
        end
    end

endmodule

// File: doc/prefetch_fifo_rd_arb.md
PREFETCH_FIFO_RD_ARB -- requirements
Module: prefetch_fifo_rd_arb

Interface
REQ-001 Parameter N_SRC, default 4, number of show-ahead prefetch FIFO read ports arbitrated (2..8).
REQ-002 Parameter DATA_W, default 32, data width per source and at the output.
REQ-003 Parameter BURST_LEN, default 16, number of beats per granted burst (2..256).
REQ-004 Parameter TIMEOUT, default 64, consecutive idle cycles mid-burst before abort (1..1023).
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  arbitration enable; gates new grants only.
REQ-008 src_vld  in  N_SRC  per-source FIFO rd_vld; head word is valid.
REQ-009 src_data  in  N_SRC*DATA_W  per-source head word; source i is slice [i*DATA_W +: DATA_W].
REQ-010 src_rd_en  out  N_SRC  per-source pop, driven to the FIFO rd_en.
REQ-011 m_valid  out  1  output beat valid.
REQ-012 m_ready  in  1  downstream accept.
REQ-013 m_data  out  DATA_W  output beat data.
REQ-014 m_id  out  clog2(N_SRC)  index of the granted source.
REQ-015 m_last  out  1  final beat of a full burst.
REQ-016 burst_abort  out  1  one-cycle pulse when a burst is closed by timeout.
REQ-017 busy  out  1  high in GRANT or BURST.

Function
REQ-018 The FSM SHALL have states IDLE, GRANT and BURST.
- IDLE->GRANT when en=1 and any src_vld=1.
- GRANT->BURST unconditionally after 1 cycle.
- BURST->IDLE on the last beat or on timeout.
REQ-019 On IDLE->GRANT, grant SHALL register the first requester found searching round-robin from (last_grant+1) mod N_SRC.
REQ-020 last_grant SHALL update to the winner when GRANT is entered.
REQ-021 In GRANT, the beat counter and idle counter SHALL clear to 0 and m_valid SHALL be 0.
REQ-022 In BURST, the output SHALL be driven combinationally from the granted source.
- m_valid = src_vld[grant].
- m_data = the grant slice of src_data.
- m_id = grant.
- src_rd_en[grant] = m_valid & m_ready.
- All other src_rd_en bits = 0.
REQ-023 A beat transfers when m_valid & m_ready; the beat counter SHALL increment by 1 per transfer.
REQ-024 m_last SHALL equal m_valid & (beat counter == BURST_LEN-1); a transfer with m_last=1 returns the FSM to IDLE.
REQ-025 The idle counter SHALL increment in BURST while src_vld[grant]=0, clear on any cycle with src_vld[grant]=1, and saturate.
REQ-026 When the idle counter reaches TIMEOUT-1 while src_vld[grant]=0, the block SHALL:
- pulse burst_abort for 1 cycle,
- emit no m_last,
- go to IDLE.
REQ-027 A stall (m_valid=1, m_ready=0) SHALL hold m_data, m_id and the counters stable and SHALL NOT count toward timeout.
REQ-028 Deasserting en SHALL NOT affect an ongoing burst; it blocks only the IDLE->GRANT transition.
REQ-029 A source deasserting src_vld in the same cycle as the final beat SHALL NOT alter m_last.
REQ-030 IDLE->GRANT SHALL be possible in the cycle after a burst ends; minimum gap between bursts is 2 cycles (IDLE, GRANT).
REQ-031 At most one src_rd_en bit SHALL be high in any cycle.

Reset
REQ-032 On rst_n=0, the block SHALL asynchronously clear to:
- state=IDLE, grant=0, last_grant=N_SRC-1.
- beat counter=0, idle counter=0.
- src_rd_en=0, m_valid=0, m_last=0, burst_abort=0, busy=0.
REQ-033 Reset release SHALL take effect on the first rising clk edge with rst_n=1; reset mid-burst drops the burst without an abort pulse.

Structure
REQ-034 FSM state encoding and the clog2 width helper SHALL live in the shared package prefetch_arb_pkg.
REQ-035 The round-robin search SHALL be a sub-module rr_pick (inputs: request vector and last_grant; outputs: winner index and any).

Verification
REQ-036 Stimulus: all 4 sources always valid, m_ready=1. Required: bursts granted 0,1,2,3,0; each burst is 16 beats with m_last on beat 15; 2-cycle gap between bursts.
REQ-037 Stimulus: only source 2 valid, m_ready toggles 1,0 every cycle. Required: 16 beats over 31 BURST cycles; m_data and m_id=2 stable while stalled; no abort.
REQ-038 Stimulus: source 1 goes empty after beat 5, TIMEOUT=64. Required: burst_abort pulses on the 64th idle cycle; no m_last; beat count seen = 5.
REQ-039 Stimulus: en=0 during beat 8 of a burst. Required: the burst completes with m_last at beat 15; no new GRANT until en=1.
REQ-040 Stimulus: rst_n=0 asynchronously at beat 3. Required: all outputs are 0 within the same cycle; after release, the first grant goes to source 0 if it is valid.
REQ-041 A checker SHALL assert onehot0(src_rd_en) and that no pop occurs without m_valid & m_ready.
